full_adder: RTL and testbench



---
 rtl/half_adder.sv | 12 +
 rtl/full_adder.sv | 53 +++++
 tb/tb_full_adder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/half_adder.sv
// Half adder: the sum and generate terms for two operand bits.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders, with a registered copy of
// the result for pipelined users. The arithmetic path is purely combinational.
module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout,
  output logic S_q,
  output logic Cout_q
);

  logic p;
  logic g1;
  logic g2;

  half_adder u_ha1 (
    .a (A),
    .b (B),
    .s (p),
    .c (g1)
  );

  half_adder u_ha2 (
    .a (p),
    .b (Cin),
    .s (S),
    .c (g2)
  );

  assign Cout = g1 | g2;

  // Stage p1: registered result, cleared asynchronously so downstream stages
  // see a known value the moment reset is raised.
  logic s_p1;
  logic cout_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_p1    <= 1'b0;
      cout_p1 <= 1'b0;
    end else begin
      s_p1    <= S;
      cout_p1 <= Cout;
    end
  end

  assign S_q    = s_p1;
  assign Cout_q = cout_p1;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: directed truth table, latency and reset checks, then a
// randomized phase scored through an expectation queue.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst;
  logic A;
  logic B;
  logic Cin;
  logic S;
  logic Cout;
  logic S_q;
  logic Cout_q;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] exp_q[$];
  bit         mon_en = 1'b0;

  full_adder dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .S      (S),
    .Cout   (Cout),
    .S_q    (S_q),
    .Cout_q (Cout_q)
  );

  always #10 clk = ~clk;

  function automatic logic [1:0] model(input int a, input int b, input int c);
    int sum;
    sum = a + b + c;
    return sum[1:0];
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each rising edge, the registered output is scored against the
  // oldest expectation pushed by the stimulus process.
  always @(posedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      logic [1:0] e;
      e = exp_q.pop_front();
      #1;
      check("reg_path", {Cout_q, S_q}, e);
    end
  end

  logic [1:0] tt[8];

  initial begin
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst = 1'b1;
    #10;
    check("reset_state", {Cout_q, S_q}, 2'b00);

    // Exhaustive truth table, 10 ns per vector, held in reset.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      {A, B, Cin} = v;
      #5;
      check($sformatf("tt_%0d", i), {Cout, S}, tt[i]);
      check($sformatf("tt_rst_%0d", i), {Cout_q, S_q}, 2'b00);
      #5;
    end

    // Worked value 101.
    {A, B, Cin} = 3'b101;
    #5;
    check("worked_101", {Cout, S}, 2'b10);

    // Register latency after reset release.
    @(negedge clk);
    rst = 1'b0;
    {A, B, Cin} = 3'b111;
    #9;
    check("pre_edge_hold", {Cout_q, S_q}, 2'b00);
    check("worked_111", {Cout, S}, 2'b11);
    @(posedge clk);
    #1;
    check("first_capture", {Cout_q, S_q}, 2'b11);

    // Asynchronous reset between edges.
    #4;
    rst = 1'b1;
    #1;
    check("async_clear", {Cout_q, S_q}, 2'b00);
    check("comb_in_reset", {Cout, S}, 2'b11);
    @(posedge clk);
    #1;
    check("held_in_reset", {Cout_q, S_q}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Cin toggling alone with A=B=1.
    A = 1'b1;
    B = 1'b1;
    for (int k = 0; k < 4; k++) begin
      Cin = k[0];
      #10;
      check($sformatf("cin_toggle_%0d", k), {Cout, S}, {1'b1, k[0]});
    end

    // Randomized phase: stimulus at falling edges, occasional reset pulses.
    @(negedge clk);
    mon_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int a, b, c;
      bit r;
      a = int'($urandom_range(1, 0));
      b = int'($urandom_range(1, 0));
      c = int'($urandom_range(1, 0));
      r = ($urandom_range(15, 0) == 0);
      A   = a[0];
      B   = b[0];
      Cin = c[0];
      rst = r;
      exp_q.push_back(r ? 2'b00 : model(a, b, c));
      #2;
      check("rand_comb", {Cout, S}, model(a, b, c));
      if (r) check("rand_async_clear", {Cout_q, S_q}, 2'b00);
      @(negedge clk);
    end
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: %0d left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
